acondicionador_botones: RTL

Input-conditioning stage that sits directly upstream of the pet-state controller. It takes NUM_BTN raw, bouncing, asynchronous push-buttons and produces clean, synchronous per-button signals for the controller:
- Comida and Medicina consume the single-cycle press pulses.
- Carino and Dormir consume the debounced level and the long-press indication.

Each button runs an independent synchronizer, debounce counter and press/hold state machine.

---
 rtl/acondicionador_botones_pkg.sv | 18 +
 rtl/antirrebote_boton.sv | 122 ++++++++++++
 rtl/acondicionador_botones.sv | 36 +++
 3 files changed

// File: rtl/acondicionador_botones_pkg.sv
// Shared types and button indices for the button-conditioning stage.
// Optional build macro: BTN_ACTIVE_LOW_EN (pins read as pressed when low).
package acondicionador_botones_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRESS_DB,
      PRESSED,
      HELD,
      REL_DB
   } btn_state_e;

   localparam int BTN_DORMIR   = 0;
   localparam int BTN_COMIDA   = 1;
   localparam int BTN_MEDICINA = 2;
   localparam int BTN_CARINO   = 3;

endpackage

// File: rtl/antirrebote_boton.sv
// One button: two-flop synchronizer, debounce counter and press/hold FSM.
// With BTN_ACTIVE_LOW_EN defined the pin is inverted ahead of the synchronizer.
module antirrebote_boton
   import acondicionador_botones_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int HOLD_CYCLES     = 1500000
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic raw_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic hold_o,
   output logic hold_pulse_o
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int HW = $clog2(HOLD_CYCLES);
   localparam logic [DW-1:0] DB_ONE    = DW'(1);
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   logic pin;
`ifdef BTN_ACTIVE_LOW_EN
   assign pin = ~raw_i;
`else
   assign pin = raw_i;
`endif

   btn_state_e    state_q;
   logic          s1_q, s2_q;
   logic [DW-1:0] db_cnt_q;
   logic [HW-1:0] hold_cnt_q;
   logic          level_q, press_q, release_q, hold_q, hold_pulse_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         s1_q         <= 1'b0;
         s2_q         <= 1'b0;
         state_q      <= IDLE;
         db_cnt_q     <= '0;
         hold_cnt_q   <= '0;
         level_q      <= 1'b0;
         press_q      <= 1'b0;
         release_q    <= 1'b0;
         hold_q       <= 1'b0;
         hold_pulse_q <= 1'b0;
      end else begin
         s1_q         <= pin;
         s2_q         <= s1_q;
         press_q      <= 1'b0;
         release_q    <= 1'b0;
         hold_pulse_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // The sample that opens the window already counts as one stable cycle.
               if (s2_q) begin
                  state_q  <= PRESS_DB;
                  db_cnt_q <= DB_ONE;
               end
            end
            PRESS_DB: begin
               if (!s2_q) begin
                  state_q  <= IDLE;
                  db_cnt_q <= '0;
               end else if (db_cnt_q == DB_LAST) begin
                  state_q  <= PRESSED;
                  db_cnt_q <= '0;
                  level_q  <= 1'b1;
                  press_q  <= 1'b1;
               end else begin
                  db_cnt_q <= db_cnt_q + DB_ONE;
               end
            end
            PRESSED: begin
               if (!s2_q) begin
                  state_q  <= REL_DB;
                  db_cnt_q <= DB_ONE;
               end else if (hold_cnt_q == HOLD_LAST) begin
                  state_q      <= HELD;
                  hold_q       <= 1'b1;
                  hold_pulse_q <= 1'b1;
               end else begin
                  hold_cnt_q <= hold_cnt_q + HW'(1);
               end
            end
            HELD: begin
               if (!s2_q) begin
                  state_q  <= REL_DB;
                  db_cnt_q <= DB_ONE;
               end
            end
            REL_DB: begin
               // hold_q is still set here only if we came from HELD.
               if (s2_q) begin
                  state_q  <= hold_q ? HELD : PRESSED;
                  db_cnt_q <= '0;
               end else if (db_cnt_q == DB_LAST) begin
                  state_q    <= IDLE;
                  db_cnt_q   <= '0;
                  hold_cnt_q <= '0;
                  level_q    <= 1'b0;
                  hold_q     <= 1'b0;
                  release_q  <= 1'b1;
               end else begin
                  db_cnt_q <= db_cnt_q + DB_ONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign level_o      = level_q;
   assign press_o      = press_q;
   assign release_o    = release_q;
   assign hold_o       = hold_q;
   assign hold_pulse_o = hold_pulse_q;

endmodule

// File: rtl/acondicionador_botones.sv
// Conditions NUM_BTN raw push-buttons into debounced levels, press/release and long-press pulses.
// Build macro BTN_ACTIVE_LOW_EN selects active-low pins; outputs are always active-high.
module acondicionador_botones
   import acondicionador_botones_pkg::*;
#(
   parameter int NUM_BTN         = 4,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int HOLD_CYCLES     = 1500000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release,
   output logic [NUM_BTN-1:0] btn_hold,
   output logic [NUM_BTN-1:0] btn_hold_pulse
);

   for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
      antirrebote_boton #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .HOLD_CYCLES    (HOLD_CYCLES)
      ) u_btn (
         .clk_i       (clk),
         .reset_i     (reset),
         .raw_i       (btn_raw[b]),
         .level_o     (btn_level[b]),
         .press_o     (btn_press[b]),
         .release_o   (btn_release[b]),
         .hold_o      (btn_hold[b]),
         .hold_pulse_o(btn_hold_pulse[b])
      );
   end

endmodule
